// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit 3-sample majority vote, parity and framing checks
module uart_rx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_en,
  input  logic                 rx_din,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);
  localparam int MID     = BPS_CNT / 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 valid_q, valid_d, rpe_q, rpe_d, rfe_q, rfe_d;
  logic                 rx_s, fall, wrap, sp, maj, exp_par, last_data;
  always_comb begin
    sync_d    = {sync_q[1:0], rx_din};
    rx_s      = sync_q[1];
    fall      = sync_q[2] & ~rx_s;
    wrap      = cnt_q == CW'(BPS_CNT - 1);
    sp        = cnt_q == CW'(MID + 1);
    maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    exp_par   = (PARITY == 1) ? ~^shift_q : ^shift_q;
    last_data = bit_q == 4'(DATA_BITS - 1);
    samp_d    = {cnt_q == CW'(MID) ? rx_s : samp_q[1], cnt_q == CW'(MID - 1) ? rx_s : samp_q[0]};
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    rpe_d     = rpe_q;
    rfe_d     = rfe_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_en && fall) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: state_d = (sp && maj) ? S_IDLE : wrap ? S_DATA : S_START;
      S_DATA: begin
        if (sp) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          bit_d   = last_data ? '0 : bit_q + 1'b1;
          state_d = !last_data ? S_DATA : (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sp && maj != exp_par) perr_d = 1'b1;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (sp && !maj) ferr_d = 1'b1;
        // the final stop bit ends the frame at its sample point so the next start edge is never missed
        if (sp && bit_q == 4'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = shift_q;
          rpe_d   = perr_q;
          rfe_d   = ferr_d;
        end else if (wrap) bit_d = bit_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      data_d  = data_q;
      rpe_d   = rpe_q;
      rfe_d   = rfe_q;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      rpe_q   <= 1'b0;
      rfe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      rpe_q   <= rpe_d;
      rfe_q   <= rfe_d;
    end
  end
  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = rpe_q;
  assign rx_frame_err  = rfe_q;
  assign rx_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for 8N1, 8E1, 8O1 and 7N2 receivers
module tb_uart_rx_param;
  localparam int BPS = 16;
  typedef struct {logic [8:0] d; logic pe; logic fe;} exp_t;
  logic       clk = 0, rst = 1, en = 1;
  logic [2:0] line = 3'b111;
  logic [7:0] d0, de, dd;
  logic [6:0] d2;
  logic       v0, ve, vo, v2, pe0, pee, peo, pe2, fe0, fee, feo, fe2, b0, be, bo, b2;
  exp_t       q0[$], qe[$], qo[$], q2[$];
  exp_t       e0, ee, eo, e2;
  int         n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, lat0 = 0, bc;
  logic [8:0] last0 = 0;
  uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .sys_clk(clk), .sys_rst(rst), .rx_en(en), .rx_din(line[0]), .rx_data(d0), .rx_valid(v0),
    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_busy(b0));
  uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u8e1 (
    .sys_clk(clk), .sys_rst(rst), .rx_en(en), .rx_din(line[1]), .rx_data(de), .rx_valid(ve),
    .rx_parity_err(pee), .rx_frame_err(fee), .rx_busy(be));
  uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u8o1 (
    .sys_clk(clk), .sys_rst(rst), .rx_en(en), .rx_din(line[1]), .rx_data(dd), .rx_valid(vo),
    .rx_parity_err(peo), .rx_frame_err(feo), .rx_busy(bo));
  uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u7n2 (
    .sys_clk(clk), .sys_rst(rst), .rx_en(en), .rx_din(line[2]), .rx_data(d2), .rx_valid(v2),
    .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_busy(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(negedge clk) if (v0) begin
    chk("u8n1 strobe expected", 9'(q0.size() != 0), 9'd1);
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      lat0 = cyc - t0;
      chk("u8n1 data", 9'(d0), e0.d);
      chk("u8n1 parity_err", 9'(pe0), 9'(e0.pe));
      chk("u8n1 frame_err", 9'(fe0), 9'(e0.fe));
      chk("u8n1 busy at valid", 9'(b0), 9'd0);
    end
  end
  always @(negedge clk) if (ve) begin
    chk("u8e1 strobe expected", 9'(qe.size() != 0), 9'd1);
    if (qe.size() != 0) begin
      ee = qe.pop_front();
      chk("u8e1 data", 9'(de), ee.d);
      chk("u8e1 parity_err", 9'(pee), 9'(ee.pe));
      chk("u8e1 frame_err", 9'(fee), 9'(ee.fe));
    end
  end
  always @(negedge clk) if (vo) begin
    chk("u8o1 strobe expected", 9'(qo.size() != 0), 9'd1);
    if (qo.size() != 0) begin
      eo = qo.pop_front();
      chk("u8o1 data", 9'(dd), eo.d);
      chk("u8o1 parity_err", 9'(peo), 9'(eo.pe));
      chk("u8o1 frame_err", 9'(feo), 9'(eo.fe));
    end
  end
  always @(negedge clk) if (v2) begin
    chk("u7n2 strobe expected", 9'(q2.size() != 0), 9'd1);
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      chk("u7n2 data", 9'(d2), e2.d);
      chk("u7n2 parity_err", 9'(pe2), 9'(e2.pe));
      chk("u7n2 frame_err", 9'(fe2), 9'(e2.fe));
    end
  end
  // line 0: 8N1, line 1: 8 data + parity + 1 stop (even and odd receivers), line 2: 7N2
  task automatic send(input int ln, input logic [8:0] d, input logic pb, input logic [1:0] sb,
                      input int gap, input int gi);
    int   nb, ns;
    logic [8:0] m;
    logic fe, odd;
    logic bits[$];
    nb = (ln == 2) ? 7 : 8;
    ns = (ln == 2) ? 2 : 1;
    m = d & ((9'd1 << nb) - 9'd1);
    fe = !sb[0] || (ns == 2 && !sb[1]);
    odd = ($countones(m) % 2) == 1;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(m[i]);
    if (ln == 1) bits.push_back(pb);
    for (int i = 0; i < ns; i++) bits.push_back(sb[i]);
    if (ln == 0) begin
      q0.push_back(exp_t'{m, 1'b0, fe});
      last0 = m;
    end else if (ln == 1) begin
      qe.push_back(exp_t'{m, pb != odd, fe});
      qo.push_back(exp_t'{m, pb == odd, fe});
    end else q2.push_back(exp_t'{m, 1'b0, fe});
    for (int c = 0; c < bits.size() * BPS; c++) begin
      @(negedge clk);
      if (c == 0 && ln == 0) t0 = cyc;
      line[ln] = bits[c / BPS] ^ (c == gi);
    end
    repeat (gap) begin
      @(negedge clk);
      line[ln] = 1'b1;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset data", 9'(d0), 9'd0);
    chk("reset valid", 9'(v0), 9'd0);
    chk("reset parity_err", 9'(pe0), 9'd0);
    chk("reset frame_err", 9'(fe0), 9'd0);
    chk("reset busy", 9'(b0), 9'd0);
    rst = 0;
    repeat (5) @(negedge clk);
    send(0, 9'hA5, 1'b0, 2'b11, 20, -1);
    chk("8N1 valid latency", 9'(lat0), 9'(9 * BPS + BPS / 2 + 1 + 1 + 3));
    send(1, 9'h03, 1'b0, 2'b11, 20, -1);
    send(1, 9'h03, 1'b1, 2'b11, 20, -1);
    send(0, 9'h5A, 1'b0, 2'b00, 20, -1);
    q0.push_back(exp_t'{9'h0, 1'b0, 1'b1});
    last0 = 9'h0;
    repeat (12 * BPS) begin
      @(negedge clk);
      line[0] = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      line[0] = 1'b1;
    end
    send(0, 9'h11, 1'b0, 2'b11, 20, -1);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      line[0] = (i < 4) ? 1'b0 : 1'b1;
      bc += int'(b0);
    end
    chk("glitch busy cycles", 9'(bc), 9'(BPS / 2 + 2));
    send(0, 9'h3C, 1'b0, 2'b11, 20, -1);
    send(0, 9'hFF, 1'b0, 2'b11, 20, 4 * BPS + BPS / 2 + 1);
    send(2, 9'h55, 1'b0, 2'b11, 0, -1);
    send(2, 9'h2A, 1'b0, 2'b11, 20, -1);
    for (int i = 0; i < 24; i++)
      send(i % 3, 9'($urandom), 1'($urandom_range(0, 1)),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)}, $urandom_range(2, 30), -1);
    repeat (40) begin
      @(negedge clk);
      line[0] = 1'b0;
    end
    chk("busy mid-frame", 9'(b0), 9'd1);
    en = 0;
    @(negedge clk);
    chk("busy after rx_en low", 9'(b0), 9'd0);
    line[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("data held after rx_en low", 9'(d0), last0);
    en = 1;
    repeat (40) begin
      @(negedge clk);
      line[0] = 1'b0;
    end
    rst = 1;
    line[0] = 1'b1;
    @(negedge clk);
    rst = 0;
    chk("mid-frame reset data", 9'(d0), 9'd0);
    chk("mid-frame reset flags", {7'd0, pe0, fe0}, 9'd0);
    chk("mid-frame reset busy/valid", {7'd0, b0, v0}, 9'd0);
    repeat (40) @(negedge clk);
    chk("u8n1 frames outstanding", 9'(q0.size()), 9'd0);
    chk("u8e1 frames outstanding", 9'(qe.size()), 9'd0);
    chk("u8o1 frames outstanding", 9'(qo.size()), 9'd0);
    chk("u7n2 frames outstanding", 9'(q2.size()), 9'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
